// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status-bit positions, default width and the
// state encoding of the requester arbiter that fronts the ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int OPC_W     = 3;

  // Codes 5..7 are reserved; they reach the ALU untouched and yield zero.
  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLT = 3'd4
  } alu_op_t;

  localparam int STAT_N = 3;
  localparam int STAT_Z = 2;
  localparam int STAT_C = 1;
  localparam int STAT_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters (master) and the shared
// ALU arbiter (slave).
interface alu_arbiter_if import alu_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = ALU_WIDTH
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0]      req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]      req_b;
  logic [NUM_REQ-1:0][OPC_W-1:0]      req_opcode;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0]                 rsp_ready;
  logic [WIDTH-1:0]                   rsp_result;
  logic [3:0]                         rsp_status;
  logic                               busy;

  modport master (
    output req_valid, req_a, req_b, req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_status, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_status, busy
  );

endinterface

// File: rtl/ALU.sv
// Combinational ALU: ADD/SUB/AND/OR/SLT with {N,Z,C,V} status.
// C is carry-out for ADD and borrow for SUB; logic ops and SLT clear C and V.
module ALU import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OPC_W-1:0] i_opcode,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_status
);

  logic [WIDTH:0] w_ext;
  logic           w_c;
  logic           w_v;

  always_comb begin
    w_ext    = '0;
    o_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_ext    = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_ext[WIDTH-1:0];
        w_c      = w_ext[WIDTH];
        w_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_ext    = {1'b0, i_a} - {1'b0, i_b};
        o_result = w_ext[WIDTH-1:0];
        w_c      = w_ext[WIDTH];
        w_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

  always_comb begin
    o_status         = '0;
    o_status[STAT_N] = o_result[WIDTH-1];
    o_status[STAT_Z] = (o_result == '0);
    o_status[STAT_C] = w_c;
    o_status[STAT_V] = w_v;
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin selector: first asserted request searching upward from
// i_last+1 (modulo NUM_REQ). Purely combinational, reusable for any shared unit.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_found
);

  logic [IDX_W-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant in IDLE,
// registered operands in EXEC, registered result held in RESP until accepted.
module alu_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rstn,
  alu_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [OPC_W-1:0]   r_op;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_status;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_busy;

  logic [IDX_W-1:0]   w_pick;
  logic               w_found;
  logic               w_hs;
  logic [WIDTH-1:0]   w_alu_result;
  logic [3:0]         w_alu_status;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_found (w_found)
  );

  // The picker only reports a hit on an asserted valid, so ready implies handshake.
  assign w_hs = rstn && (r_state == ST_IDLE) && w_found;

  always_comb begin
    bus.req_ready = '0;
    if (w_hs) bus.req_ready[w_pick] = 1'b1;
  end

  ALU #(
    .WIDTH    (WIDTH)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_opcode (r_op),
    .o_result (w_alu_result),
    .o_status (w_alu_status)
  );

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_a  <= bus.req_a[w_pick];
      r_b  <= bus.req_b[w_pick];
      r_op <= bus.req_opcode[w_pick];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_result    <= '0;
      r_status    <= '0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result    <= w_alu_result;
          r_status    <= w_alu_status;
          r_rsp_valid <= NUM_REQ'(1) << r_grant;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[r_grant]) begin
            r_rsp_valid <= '0;
            r_last      <= r_grant;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_status = r_status;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural model of
// the ALU arithmetic and the round-robin grant order.
module tb_alu_arbiter;

  localparam int NR = 2;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rstn;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_last;
  int          grants[$];
  logic [31:0] pa[2];
  logic [31:0] pb[2];
  logic [2:0]  pop[2];
  logic [31:0] obs_res;
  logic [3:0]  obs_stat;
  logic [1:0]  obs_rdy;

  alu_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  alu_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: {N,Z,C,V,result} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint      sa, sb, sr, ua, ub;
    logic [31:0] r;
    logic        c, v;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = ua < ub;
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic int rr_next(input int last, input logic [1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (v[i[0]]) return i;
    end
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input bit p);
    logic [1:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input bit p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    pa[p]  = a;
    pb[p]  = b;
    pop[p] = op;
    bus.req_a[p]      = a;
    bus.req_b[p]      = b;
    bus.req_opcode[p] = op;
    bus.req_valid[p]  = 1'b1;
  endtask

  // Entered at a falling edge in IDLE with requests already driven; returns at
  // a falling edge back in IDLE after the response handshake.
  task automatic op_cycle(input int bp, input bit keep);
    int          gi;
    bit          g;
    logic [35:0] exp;
    gi = rr_next(m_last, bus.req_valid);
    if (gi < 0) begin
      $display("FAIL op_cycle: called with no valid request");
      $fatal(1, "bench sequencing");
    end
    g = gi[0];
    #1;
    obs_rdy = bus.req_ready;
    check("grant", bus.req_ready, onehot(g));
    exp = model(pa[g], pb[g], pop[g]);
    grants.push_back(gi);
    @(negedge clk);
    if (keep) set_req(g, rnd32(), rnd32(), 3'($urandom_range(0, 7)));
    else      bus.req_valid[g] = 1'b0;
    check("exec_ready", bus.req_ready, 2'b00);
    check("exec_busy", bus.busy, 1'b1);
    check("exec_rspv", bus.rsp_valid, 2'b00);
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, onehot(g));
    check("rsp_result", bus.rsp_result, exp[31:0]);
    check("rsp_status", bus.rsp_status, exp[35:32]);
    obs_res  = bus.rsp_result;
    obs_stat = bus.rsp_status;
    for (int i = 0; i < bp; i++) begin
      bus.rsp_ready = ~onehot(g);
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, onehot(g));
      check("bp_result", bus.rsp_result, exp[31:0]);
      check("bp_status", bus.rsp_status, exp[35:32]);
      check("bp_ready", bus.req_ready, 2'b00);
      check("bp_busy", bus.busy, 1'b1);
    end
    bus.rsp_ready = onehot(g);
    @(negedge clk);
    bus.rsp_ready = '0;
    check("ack_valid", bus.rsp_valid, 2'b00);
    check("ack_busy", bus.busy, 1'b0);
    m_last = gi;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_last = NR - 1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn           = 1'b0;
    m_last         = NR - 1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_opcode = '0;
    bus.rsp_ready  = '0;

    // Reset state, with a request pending that must not be acknowledged.
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_result", bus.rsp_result, 32'h0);
    check("rst_status", bus.rsp_status, 4'h0);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    bus.req_valid = '0;
    rstn = 1'b1;
    #1;
    check("idle_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    // Single ADD on port 0.
    set_req(0, 32'd3, 32'd11, 3'd0);
    op_cycle(0, 1'b0);
    check("single_result", obs_res, 32'd14);
    check("single_status", obs_stat, 4'b0000);

    // Zero flag from SUB on port 1.
    set_req(1, 32'd5, 32'd5, 3'd1);
    op_cycle(0, 1'b0);
    check("zero_result", obs_res, 32'd0);
    check("zero_flagZ", obs_stat[2], 1'b1);
    check("zero_flagN", obs_stat[3], 1'b0);

    // Contention from reset: both held valid for four operations.
    do_reset();
    grants.delete();
    set_req(0, rnd32(), rnd32(), 3'($urandom_range(0, 4)));
    set_req(1, rnd32(), rnd32(), 3'($urandom_range(0, 4)));
    for (int i = 0; i < 4; i++) op_cycle(0, 1'b1);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) check("rr_order", grants[i], i % 2);

    // Backpressure with the other port waiting.
    set_req(0, rnd32(), rnd32(), 3'd1);
    set_req(1, rnd32(), rnd32(), 3'd0);
    op_cycle(5, 1'b0);
    op_cycle(0, 1'b0);

    // Wrap-around ADD.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'd0);
    op_cycle(0, 1'b0);
    check("wrap_result", obs_res, 32'h0);
    check("wrap_flagZ", obs_stat[2], 1'b1);
    check("wrap_flagC", obs_stat[1], 1'b1);

    // Reset during EXEC: port 1 wins (last grant was 0), then is aborted.
    set_req(1, 32'd100, 32'd7, 3'd0);
    set_req(0, 32'd9, 32'd4, 3'd1);
    #1;
    check("mid_grant", bus.req_ready, 2'b10);
    @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rsp_valid", bus.rsp_valid, 2'b00);
    check("mid_busy_clr", bus.busy, 1'b0);
    check("mid_result", bus.rsp_result, 32'h0);
    check("mid_status", bus.rsp_status, 4'h0);
    check("mid_ready", bus.req_ready, 2'b00);
    m_last = NR - 1;
    set_req(1, 32'd20, 32'd22, 3'd3);
    @(negedge clk);
    rstn = 1'b1;
    check("post_rst_rspv", bus.rsp_valid, 2'b00);
    op_cycle(0, 1'b0);
    check("post_rst_grant0", obs_rdy, 2'b01);
    check("post_rst_res0", obs_res, 32'd5);
    op_cycle(0, 1'b0);
    check("post_rst_res1", obs_res, 32'd22);

    // Randomized traffic against the model.
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < NR; p++) begin
        bit pb1;
        pb1 = p[0];
        if (!bus.req_valid[pb1] && ($urandom_range(0, 1) == 1))
          set_req(pb1, rnd32(), rnd32(), 3'($urandom_range(0, 7)));
      end
      if (bus.req_valid == 2'b00)
        set_req(1'($urandom_range(0, 1)), rnd32(), rnd32(), 3'($urandom_range(0, 7)));
      op_cycle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    bus.req_valid = '0;
    #1;
    check("end_idle_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    check("end_idle_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
